// File: rtl/framebuf_scheduler.sv
// Burst scheduler for a three-port SDRAM frame buffer: arbitrates refresh, one
// write FIFO and two read FIFOs, and walks each port's address window.
module framebuf_scheduler #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned BURST_LEN  = 128,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned WR_BASE    = 0,
  parameter int unsigned WR_MAX     = 640 * 506,
  parameter int unsigned RD1_BASE   = 640 * 13,
  parameter int unsigned RD1_MAX    = 640 * 253,
  parameter int unsigned RD2_BASE   = 640 * 266,
  parameter int unsigned RD2_MAX    = 640 * 506
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [9:0]        wr_level,
  input  logic [9:0]        rd1_level,
  input  logic [9:0]        rd2_level,
  input  logic              refresh_req,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_port,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [8:0]        cmd_len,
  input  logic              cmd_done,
  output logic              busy
);

  localparam int unsigned LEN_W     = 9;
  localparam int unsigned EXT_W     = ADDR_W + 1;
  localparam int unsigned RD_THRESH = FIFO_DEPTH - BURST_LEN;

  localparam logic [1:0] PORT_WR  = 2'd0;
  localparam logic [1:0] PORT_RD1 = 2'd1;
  localparam logic [1:0] PORT_RD2 = 2'd2;
  localparam logic [1:0] PORT_REF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [1:0]          cmd_port_q, cmd_port_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]    cmd_len_q, cmd_len_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd1_ptr_q, rd1_ptr_d;
  logic [ADDR_W-1:0]   rd2_ptr_q, rd2_ptr_d;
  logic                last_rd2_q, last_rd2_d;
  logic                load_pend_q, load_pend_d;

  logic                wr_rq, rd1_rq, rd2_rq, pick_rd2;

  // Step one burst forward, or back to base when the following burst would not fit.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr,
                                                 input logic [ADDR_W-1:0] base,
                                                 input logic [EXT_W-1:0]  max);
    logic [EXT_W-1:0] step_ptr;
    logic [EXT_W-1:0] look_ptr;
    step_ptr = EXT_W'(ptr) + EXT_W'(BURST_LEN);
    look_ptr = step_ptr + EXT_W'(BURST_LEN);
    next_ptr = (look_ptr > max) ? base : step_ptr[ADDR_W-1:0];
  endfunction

  assign wr_rq    = 32'(wr_level) >= BURST_LEN;
  assign rd1_rq   = 32'(rd1_level) <= RD_THRESH;
  assign rd2_rq   = 32'(rd2_level) <= RD_THRESH;
  assign pick_rd2 = (rd1_rq && rd2_rq) ? ~last_rd2_q : rd2_rq;

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_port_d  = cmd_port_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    wr_ptr_d    = wr_ptr_q;
    rd1_ptr_d   = rd1_ptr_q;
    rd2_ptr_d   = rd2_ptr_q;
    last_rd2_d  = last_rd2_q;
    load_pend_d = load_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          wr_ptr_d  = ADDR_W'(WR_BASE);
          rd1_ptr_d = ADDR_W'(RD1_BASE);
          rd2_ptr_d = ADDR_W'(RD2_BASE);
        end else if (refresh_req || wr_rq || rd1_rq || rd2_rq) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_len_d   = LEN_W'(BURST_LEN);
          if (refresh_req) begin
            cmd_port_d = PORT_REF;
            cmd_addr_d = '0;
            cmd_len_d  = '0;
          end else if (wr_rq) begin
            cmd_port_d = PORT_WR;
            cmd_addr_d = wr_ptr_q;
          end else begin
            last_rd2_d = pick_rd2;
            cmd_port_d = pick_rd2 ? PORT_RD2 : PORT_RD1;
            cmd_addr_d = pick_rd2 ? rd2_ptr_q : rd1_ptr_q;
          end
        end
      end

      ST_ISSUE: begin
        if (load) load_pend_d = 1'b1;
        if (cmd_ready) begin
          state_d     = ST_BUSY;
          cmd_valid_d = 1'b0;
        end
      end

      ST_BUSY: begin
        if (load) load_pend_d = 1'b1;
        if (cmd_done) begin
          state_d     = ST_IDLE;
          load_pend_d = 1'b0;
          // A reload requested during the burst wins over that burst's advance.
          if (load_pend_q || load) begin
            wr_ptr_d  = ADDR_W'(WR_BASE);
            rd1_ptr_d = ADDR_W'(RD1_BASE);
            rd2_ptr_d = ADDR_W'(RD2_BASE);
          end else begin
            case (cmd_port_q)
              PORT_WR:  wr_ptr_d  = next_ptr(wr_ptr_q,  ADDR_W'(WR_BASE),  EXT_W'(WR_MAX));
              PORT_RD1: rd1_ptr_d = next_ptr(rd1_ptr_q, ADDR_W'(RD1_BASE), EXT_W'(RD1_MAX));
              PORT_RD2: rd2_ptr_d = next_ptr(rd2_ptr_q, ADDR_W'(RD2_BASE), EXT_W'(RD2_MAX));
              default:  ;
            endcase
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_port_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= ADDR_W'(WR_BASE);
      rd1_ptr_q   <= ADDR_W'(RD1_BASE);
      rd2_ptr_q   <= ADDR_W'(RD2_BASE);
      last_rd2_q  <= 1'b1;
      load_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_port_q  <= cmd_port_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd1_ptr_q   <= rd1_ptr_d;
      rd2_ptr_q   <= rd2_ptr_d;
      last_rd2_q  <= last_rd2_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_port  = cmd_port_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_framebuf_scheduler.sv
// Bench for framebuf_scheduler: directed vector table, corner sequences, and
// randomized transactions checked against a transaction-level model.
module tb_framebuf_scheduler;

  localparam int BL    = 128;
  localparam int DEPTH = 512;

  logic        clock = 1'b0;
  logic        reset, load, refresh_req, cmd_ready, cmd_done;
  logic [9:0]  wr_level, rd1_level, rd2_level;
  logic        cmd_valid, busy;
  logic [1:0]  cmd_port;
  logic [22:0] cmd_addr;
  logic [8:0]  cmd_len;

  always #5 clock = ~clock;

  framebuf_scheduler dut (
    .clock(clock), .reset(reset), .load(load),
    .wr_level(wr_level), .rd1_level(rd1_level), .rd2_level(rd2_level),
    .refresh_req(refresh_req), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_port(cmd_port), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_done(cmd_done), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level reference state: pointers, last read port (1/2), pending reload.
  int m_ptr[3];
  int m_base[3] = '{0, 8320, 170240};
  int m_max[3]  = '{323840, 161920, 323840};
  int m_last;
  bit m_pend;

  typedef struct {
    int wr; int rd1; int rd2; bit rf; int port; int addr;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int m_pick(input int wr, input int r1, input int r2, input bit rf);
    bit q1, q2;
    q1 = (r1 <= DEPTH - BL);
    q2 = (r2 <= DEPTH - BL);
    if (rf) return 3;
    if (wr >= BL) return 0;
    if (q1 && q2) return 3 - m_last;
    if (q1) return 1;
    if (q2) return 2;
    return -1;
  endfunction

  task automatic m_reload();
    for (int i = 0; i < 3; i++) m_ptr[i] = m_base[i];
  endtask

  task automatic m_finish(input int port);
    if (m_pend) begin
      m_reload();
      m_pend = 0;
    end else if (port < 3) begin
      if (m_ptr[port] + 2 * BL > m_max[port]) m_ptr[port] = m_base[port];
      else m_ptr[port] = m_ptr[port] + BL;
    end
  endtask

  function automatic int rnd_lvl();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 1023));
      1:       return int'($urandom_range(120, 135));
      2:       return int'($urandom_range(378, 390));
      default: return int'($urandom_range(500, 1023));
    endcase
  endfunction

  task automatic set_quiet();
    wr_level = 10'd0; rd1_level = 10'd1023; rd2_level = 10'd1023; refresh_req = 1'b0;
  endtask

  // One full grant/accept/done cycle; fields checked against the model every cycle.
  task automatic do_txn(input int wr, input int r1, input int r2, input bit rf,
                        input int rdy_dly, input int done_dly, input bit ld_busy,
                        output int got_port, output int got_addr);
    int          ep;
    logic [34:0] exp_cmd;
    wr_level = 10'(wr); rd1_level = 10'(r1); rd2_level = 10'(r2); refresh_req = rf;
    ep = m_pick(wr, r1, r2, rf);
    step();
    got_port = cmd_valid ? int'(cmd_port) : -1;
    got_addr = int'(cmd_addr);
    if (ep < 0) begin
      chk("no_grant", 64'({cmd_valid, busy}), 64'(2'b00));
      return;
    end
    exp_cmd = {1'b1, 2'(ep), 23'((ep == 3) ? 0 : m_ptr[ep]), 9'((ep == 3) ? 0 : BL)};
    chk("grant", 64'({cmd_valid, cmd_port, cmd_addr, cmd_len}), 64'(exp_cmd));
    chk("busy_issue", 64'(busy), 64'(1));
    if (ep == 1 || ep == 2) m_last = ep;
    cmd_ready = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      wr_level = 10'($urandom_range(0, 1023));
      rd1_level = 10'($urandom_range(0, 1023));
      rd2_level = 10'($urandom_range(0, 1023));
      refresh_req = 1'($urandom_range(0, 1));
      cmd_done = 1'($urandom_range(0, 1));
      step();
      chk("hold", 64'({cmd_valid, cmd_port, cmd_addr, cmd_len}), 64'(exp_cmd));
    end
    cmd_done = 1'b0;
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("accepted", 64'({cmd_valid, busy}), 64'(2'b01));
    if (ld_busy) begin
      load = 1'b1;
      m_pend = 1;
      step();
      load = 1'b0;
    end
    repeat (done_dly) step();
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    chk("done_idle", 64'({cmd_valid, busy}), 64'(2'b00));
    m_finish(ep);
  endtask

  task automatic do_load_idle(input int wr, input int r1, input int r2, input bit rf);
    wr_level = 10'(wr); rd1_level = 10'(r1); rd2_level = 10'(r2); refresh_req = rf;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("load_idle_no_grant", 64'({cmd_valid, busy}), 64'(2'b00));
    m_reload();
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b1; cmd_done = 1'b1; cmd_ready = 1'b1;
    wr_level = 10'd300; refresh_req = 1'b1;
    step();
    step();
    chk("reset_outputs", 64'({cmd_valid, busy, cmd_port, cmd_addr, cmd_len}), 64'(0));
    reset = 1'b0; load = 1'b0; cmd_done = 1'b0; cmd_ready = 1'b0;
    set_quiet();
    m_reload();
    m_last = 2;
    m_pend = 0;
  endtask

  initial begin
    int gp, ga, guard;
    tbl[0]  = '{128, 500, 500, 1'b0, 0, 0};
    tbl[1]  = '{0, 500, 500, 1'b0, -1, 0};
    tbl[2]  = '{0, 0, 0, 1'b0, 1, 8320};
    tbl[3]  = '{0, 0, 0, 1'b0, 2, 170240};
    tbl[4]  = '{0, 0, 0, 1'b0, 1, 8448};
    tbl[5]  = '{0, 0, 0, 1'b0, 2, 170368};
    tbl[6]  = '{300, 0, 0, 1'b1, 3, 0};
    tbl[7]  = '{300, 0, 0, 1'b0, 0, 128};
    tbl[8]  = '{0, 0, 500, 1'b0, 1, 8576};
    tbl[9]  = '{0, 0, 500, 1'b0, 1, 8704};
    tbl[10] = '{0, 0, 0, 1'b0, 2, 170496};
    tbl[11] = '{0, 500, 0, 1'b0, 2, 170624};
    tbl[12] = '{0, 0, 0, 1'b0, 1, 8832};
    tbl[13] = '{127, 385, 384, 1'b0, 2, 170752};
    tbl[14] = '{128, 384, 1023, 1'b0, 0, 256};

    reset = 1'b1; load = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
    set_quiet();
    do_reset();

    for (int i = 0; i < 15; i++) begin
      do_txn(tbl[i].wr, tbl[i].rd1, tbl[i].rd2, tbl[i].rf, i % 3, i % 2, 1'b0, gp, ga);
      chk($sformatf("tbl%0d_port", i), 64'(gp), 64'(tbl[i].port));
      if (tbl[i].port == 3) chk($sformatf("tbl%0d_ref_len", i), 64'(cmd_len), 64'(0));
      else if (tbl[i].port >= 0) chk($sformatf("tbl%0d_addr", i), 64'(ga), 64'(tbl[i].addr));
    end

    // Backpressure: RD1 held for 10 cycles while levels wander.
    do_txn(0, 0, 1023, 1'b0, 10, 1, 1'b0, gp, ga);
    chk("bp_port", 64'(gp), 64'(1));
    chk("bp_addr", 64'(ga), 64'(8960));

    // Load in IDLE grants nothing and rebases pointers.
    do_load_idle(300, 0, 0, 1'b0);
    do_txn(300, 1023, 1023, 1'b0, 0, 0, 1'b0, gp, ga);
    chk("after_load_wr_addr", 64'(ga), 64'(0));

    // Load pending during a WR burst at pointer 1280.
    for (int i = 0; i < 9; i++) do_txn(300, 1023, 1023, 1'b0, 0, 0, 1'b0, gp, ga);
    do_txn(300, 1023, 1023, 1'b0, 1, 2, 1'b1, gp, ga);
    chk("pend_burst_addr", 64'(ga), 64'(1280));
    do_txn(300, 1023, 1023, 1'b0, 0, 0, 1'b0, gp, ga);
    chk("pend_wr_rebased", 64'(ga), 64'(0));
    do_txn(0, 0, 1023, 1'b0, 0, 0, 1'b0, gp, ga);
    chk("pend_rd1_rebased", 64'(ga), 64'(8320));
    do_txn(0, 1023, 0, 1'b0, 0, 0, 1'b0, gp, ga);
    chk("pend_rd2_rebased", 64'(ga), 64'(170240));

    // Wrap: walk RD1 to its last legal burst start.
    guard = 0;
    while (m_ptr[1] != 161792 && guard < 1400) begin
      do_txn(0, 0, 1023, 1'b0, 0, 0, 1'b0, gp, ga);
      guard++;
    end
    chk("wrap_reached", 64'(m_ptr[1]), 64'(161792));
    do_txn(0, 0, 1023, 1'b0, 0, 0, 1'b0, gp, ga);
    chk("wrap_last_addr", 64'(ga), 64'(161792));
    do_txn(0, 0, 1023, 1'b0, 0, 0, 1'b0, gp, ga);
    chk("wrap_rebased", 64'(ga), 64'(8320));

    // Reset mid-burst: no advance, round-robin restarts at RD1.
    wr_level = 10'd300;
    step();
    chk("mid_reset_grant", 64'({cmd_valid, cmd_port}), 64'({1'b1, 2'd0}));
    cmd_ready = 1'b1;
    step();
    do_reset();
    do_txn(300, 1023, 1023, 1'b0, 0, 0, 1'b0, gp, ga);
    chk("mid_reset_wr_addr", 64'(ga), 64'(0));
    do_txn(0, 0, 0, 1'b0, 0, 0, 1'b0, gp, ga);
    chk("mid_reset_rr", 64'(gp), 64'(1));

    // Randomized transactions against the model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0)
        do_load_idle(rnd_lvl(), rnd_lvl(), rnd_lvl(), 1'($urandom_range(0, 1)));
      else
        do_txn(rnd_lvl(), rnd_lvl(), rnd_lvl(), ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), gp, ga);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/framebuf_scheduler.md
FRAMEBUF_SCHEDULER -- requirements
Module: framebuf_scheduler

Interface
REQ-001 Parameter ADDR_W, default 23: SDRAM word-address width.
REQ-002 Parameter BURST_LEN, default 128: words per burst.
REQ-003 Parameter FIFO_DEPTH, default 512: depth of each port FIFO, in words.
REQ-004 Parameters WR_BASE, default 0; WR_MAX, default 640*506: write-port address window [base, max).
REQ-005 Parameters RD1_BASE, default 640*13; RD1_MAX, default 640*253: odd-field read window.
REQ-006 Parameters RD2_BASE, default 640*266; RD2_MAX, default 640*506: even-field read window.
REQ-007 clock  in  1  sole clock; every register updates on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 load  in  1  request to reload all three address pointers to their bases.
REQ-010 wr_level  in  10  word count of the write FIFO.
REQ-011 rd1_level, rd2_level  in  10 each  word counts of the read FIFOs.
REQ-012 refresh_req  in  1  level signal; the SDRAM needs an auto-refresh.
REQ-013 cmd_valid  out  1  command offered to the SDRAM engine.
REQ-014 cmd_ready  in  1  the engine accepts the command.
REQ-015 cmd_port  out  2  command source: 0=WR, 1=RD1, 2=RD2, 3=REFRESH.
REQ-016 cmd_addr  out  ADDR_W  burst start address.
REQ-017 cmd_len  out  9  burst length.
REQ-018 cmd_done  in  1  single-cycle pulse; the accepted burst or refresh has finished.
REQ-019 busy  out  1  high in ISSUE and BUSY states.

Function
REQ-020 Request qualification, evaluated only in IDLE:
- wr_rq = wr_level >= BURST_LEN.
- rdN_rq = rdN_level <= FIFO_DEPTH-BURST_LEN.
- Comparisons are unsigned.
REQ-021 FSM states: IDLE, ISSUE, BUSY.
- IDLE -> ISSUE when any request is qualified.
- ISSUE -> BUSY on the cycle with cmd_valid && cmd_ready.
- BUSY -> IDLE on cmd_done.
REQ-022 Priority, fixed at the IDLE->ISSUE transition: refresh_req > wr_rq > RD1/RD2 round-robin.
REQ-023 Round-robin: a last_rd flag records the most recently granted read port.
- When both reads request, the other port wins.
- When only one read requests, it wins and last_rd updates.
- last_rd resets to RD2, so RD1 wins first.
REQ-024 In ISSUE, cmd_valid=1 and cmd_port/cmd_addr/cmd_len hold stable until accepted.
- Request inputs that change during ISSUE have no effect.
REQ-025 cmd_len = BURST_LEN for data ports and 0 for REFRESH; cmd_addr = 0 for REFRESH.
REQ-026 Latency:
- cmd_valid rises one cycle after the IDLE cycle that detects the request.
- The minimum gap from cmd_done to the next cmd_valid is 2 cycles.
REQ-027 Pointer advance happens on cmd_done, for data ports only. The granted pointer becomes ptr+BURST_LEN.
REQ-028 Wrap: if ptr+BURST_LEN+BURST_LEN > MAX for the port, the pointer becomes its BASE instead.
- Arithmetic is ADDR_W+1 bits wide so it cannot overflow.
REQ-029 REFRESH grants never modify pointers or last_rd.
REQ-030 load in IDLE: all pointers return to BASE on the next edge, and that cycle grants nothing.
REQ-031 load in ISSUE or BUSY: a load_pend flag is set.
- The reload happens on the cmd_done edge and overrides that burst's advance.
- load_pend then clears.
REQ-032 A cmd_done pulse outside BUSY is ignored.
REQ-033 cmd_ready outside ISSUE is ignored.

Reset
REQ-034 While reset=1:
- State = IDLE.
- cmd_valid=0, busy=0, cmd_port=0, cmd_addr=0, cmd_len=0.
- Pointers = WR_BASE/RD1_BASE/RD2_BASE.
- last_rd = RD2, load_pend = 0.
REQ-035 Reset asserted mid-burst abandons the burst with no pointer advance. The bench must not expect a cmd_done response to it.
REQ-036 Reset overrides load and every other input.

Verification
REQ-037 Write grant:
- Stimulus: after reset, wr_level=128, rd levels=500, cmd_ready=1.
- Response: cmd_valid with port=0, addr=0, len=128.
- After cmd_done, the WR pointer = 128.
REQ-038 Read round-robin:
- Stimulus: wr_level=0, rd1_level=rd2_level=0, repeated grants.
- Response: ports alternate 1,2,1,2.
- Addresses: 8320, 170240, 8448, 170368.
REQ-039 Refresh priority:
- Stimulus: refresh_req=1 and wr_level=300 in the same IDLE cycle.
- Response: port=3, len=0.
- The next grant is port 0, with the WR pointer unchanged.
REQ-040 Wrap:
- Stimulus: RD1 pointer preloaded by bursts to 161792; grant RD1 and pulse cmd_done.
- Response: addr=161792, then the pointer returns to 8320, because 161792+256 > 161920.
REQ-041 Backpressure:
- Stimulus: hold cmd_ready=0 for 10 cycles while rd1_level changes.
- Response: cmd_valid and all fields stay stable; acceptance happens on the first cmd_ready=1.
REQ-042 Load pending:
- Stimulus: load pulse during BUSY of a WR burst at pointer 1280.
- Response: after cmd_done, the WR pointer = 0 (not 1408), and the RD pointers = their bases.
